sipo_frame_ctrl: RTL

Controller that sequences a WIDTH-bit serial-in/parallel-out shift register into framed word reception. Detects a start bit on an idle-low serial line, counts WIDTH data bits into its internal SIPO register under a bit-strobe, optionally checks an even-parity bit, and presents the completed word on a valid/ready output handshake with overrun detection. Sits between a serial bit source and downstream parallel consumers.

---
 rtl/sipo_frame_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sipo_frame_ctrl.sv
// Framed serial receiver: start-bit detect, WIDTH-bit SIPO capture, optional even parity,
// and a single-entry valid/ready output slot with sticky overrun.
module sipo_frame_ctrl #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             data_ready,
  input  logic             clr_overrun,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             parity_err,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [WIDTH-1:0]  data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              parity_err_q, parity_err_d;
  logic              overrun_q, overrun_d;

  logic              complete;
  logic [WIDTH-1:0]  word;
  logic              word_err;
  logic              slot_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      shreg_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    complete = 1'b0;
    word     = {shreg_q[WIDTH-2:0], serial_in};
    word_err = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bit_valid && serial_in) begin
          state_d = StShift;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
      StShift: begin
        if (bit_valid) begin
          shreg_d = {shreg_q[WIDTH-2:0], serial_in};
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            if (PARITY_EN) begin
              state_d = StParity;
            end else begin
              state_d  = StIdle;
              complete = 1'b1;
            end
          end
        end
      end
      StParity: begin
        if (bit_valid) begin
          state_d  = StIdle;
          complete = 1'b1;
          word     = shreg_q;
          word_err = (^shreg_q) ^ serial_in;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A completing frame may reuse the slot on the same edge the old word is accepted.
  always_comb begin
    slot_busy    = data_valid_q && !data_ready;
    data_out_d   = data_out_q;
    parity_err_d = parity_err_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q && !clr_overrun;
    if (complete && !slot_busy) begin
      data_out_d   = word;
      parity_err_d = PARITY_EN ? word_err : 1'b0;
      data_valid_d = 1'b1;
    end else if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end
    if (complete && slot_busy) begin
      overrun_d = 1'b1;
    end
  end

  always_comb begin
    data_out   = data_out_q;
    data_valid = data_valid_q;
    parity_err = parity_err_q;
    overrun    = overrun_q;
    busy       = (state_q != StIdle);
  end

endmodule
